fetch_top: RTL
==============

Name: fetch_top

Overview:
- Instruction-fetch stage: the producer end of the fetch→decode boundary.
- Owns the PC and issues requests to the instruction memory or cache.
- Delivers registered pc/instruction/valid to the decode stage.
- Holds output under decode stall; redirects on decode jumps and memory-stage taken branches, squashing wrong-path fetches.

Parameters:
ADDR_SIZE, 32, PC and memory address width
INSTR_SIZE, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous active-high reset
imem_req  output  1  instruction memory request
imem_addr  output  ADDR_SIZE  fetch address (current pc)
imem_ready  input  1  imem_data valid this cycle; sampled only while imem_req=1
imem_data  input  INSTR_SIZE  fetched instruction
stall  input  1  decode cannot accept; hold outputs
is_jump  input  1  decode-stage jump, combinational from out_instruction
jump_addr  input  ADDR_SIZE  jump target
branch_taken  input  1  memory-stage taken branch
branch_addr  input  ADDR_SIZE  branch target
out_pc  output  ADDR_SIZE  registered pc of out_instruction
out_instruction  output  INSTR_SIZE  registered instruction to decode
out_valid  output  1  out_instruction valid; drives decode we

Behaviour:
- One clock (clk); reset is synchronous, active-high.
- Reset values: pc=RESET_PC, state=S_REQ, out_pc=0, out_instruction=0 (NOP), out_valid=0, buffer empty.
- Reset dominates every other input, including mid-request; any response arriving in the reset cycle is dropped.
- States:
  - S_REQ: imem_req=1, imem_addr=pc.
  - S_HELD: imem_req=0; one fetched instruction is buffered.
- The instruction memory is abortable: imem_addr may change while imem_req=1, and the memory then serves the new address.
- Redirect: redir = branch_taken | (is_jump & out_valid & !stall).
  - Target priority: branch_addr over jump_addr.
  - Jump is ignored while stall=1 (decode still holds the jump).
- Per-cycle update, first matching rule wins:
  1. redir: pc<=target; out_valid<=0; out_instruction<=0; buffer discarded; same-cycle imem response discarded; state<=S_REQ. Overrides stall.
  2. S_REQ & imem_ready & !stall: out_instruction<=imem_data; out_pc<=pc; out_valid<=1; pc<=pc+4; stay S_REQ.
  3. S_REQ & imem_ready & stall: buffer<={pc,imem_data}; pc<=pc+4; outputs held; state<=S_HELD.
  4. S_HELD & !stall: outputs<=buffer; out_valid<=1; state<=S_REQ.
  5. stall (other cases): outputs held.
  6. Otherwise: out_valid<=0; out_instruction<=0 (bubble).
- Latency: with imem_ready tied high, the first instruction appears 1 cycle after reset deassertion; throughput is 1 instruction/cycle.
- Arithmetic and alignment:
  - pc+4 wraps modulo 2^ADDR_SIZE; 0xFFFF_FFFC → 0x0.
  - Targets are used unmodified; bits[1:0] are not checked.
- No architectural delay slot: the instruction fetched behind a jump or taken branch is squashed.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two outputs, each 32 bits, reset to 0, wrapping on overflow:
  - perf_fetched: +1 per rule-2 or rule-4 delivery.
  - perf_stall_cycles: +1 per cycle with imem_req=1 & !imem_ready, or state=S_HELD.
- When undefined, both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, imem_ready=1, imem_data=pc-based pattern → out_pc 0x0,0x4,0x8 on consecutive cycles from the first edge after reset release; out_valid=1.
- imem_ready held 0 for 3 cycles at pc=0x8 → imem_req=1 and imem_addr=0x8 stable; out_valid=0 for 3 cycles; then instruction for 0x8.
- stall=1 in the same cycle a response for 0xC arrives, held 2 cycles → state S_HELD, outputs unchanged; on release out_pc=0xC, then the request for 0x10.
- out_instruction = jump, is_jump=1, jump_addr=0x100, stall=0 → next out_valid=0; following imem_addr=0x100; the fetch at 0x4-after is never delivered.
- branch_taken=1, branch_addr=0x200, arriving together with imem_ready for 0x14 and with stall=1 → response dropped, out_valid=0, next imem_addr=0x200.
- FETCH_PERF_CNT_EN defined, run the scenario with 10 deliveries and 3 wait cycles → perf_fetched=10, perf_stall_cycles=3; reset mid-run → both counters 0.

Source files
------------

// File: rtl/fetch_top.sv
// fetch_top -- instruction-fetch stage, producer end of the fetch->decode
// boundary. Owns the PC, requests instructions from an abortable instruction
// memory and presents a registered pc/instruction/valid triple to decode.
//
// Ports:
//   clk, reset                   clock; synchronous active-high reset
//   imem_req, imem_addr          request and address (current pc) to memory
//   imem_ready, imem_data        response strobe and instruction from memory
//   stall                        decode cannot accept; outputs are held
//   is_jump, jump_addr           decode-stage jump (from out_instruction)
//   branch_taken, branch_addr    memory-stage taken branch
//   out_pc, out_instruction      registered instruction and its pc
//   out_valid                    out_instruction valid (decode write enable)
//   state_dbg                    fetch FSM state (0 = S_REQ, 1 = S_HELD)
//   perf_fetched,                optional performance counters, present only
//   perf_stall_cycles            when FETCH_PERF_CNT_EN is defined
//
// Handshake: the memory side completes a fetch in every cycle where
// imem_req=1 and imem_ready=1; imem_ready is ignored while imem_req=0, and
// imem_addr may change under an outstanding request (the memory then serves
// the new address). The decode side accepts out_instruction at every clock
// edge where out_valid=1 and stall=0; while stall=1 the outputs are held.
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched and
// perf_stall_cycles, 32-bit wrapping counters).

module fetch_top #(
  parameter int                    ADDR_SIZE  = 32,
  parameter int                    INSTR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_SIZE-1:0]  imem_addr,
  input  logic                  imem_ready,
  input  logic [INSTR_SIZE-1:0] imem_data,
  input  logic                  stall,
  input  logic                  is_jump,
  input  logic [ADDR_SIZE-1:0]  jump_addr,
  input  logic                  branch_taken,
  input  logic [ADDR_SIZE-1:0]  branch_addr,
  output logic [ADDR_SIZE-1:0]  out_pc,
  output logic [INSTR_SIZE-1:0] out_instruction,
  output logic                  out_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall_cycles,
`endif
  output logic                  state_dbg
);

  typedef enum logic {
    S_REQ  = 1'b0,  // requesting the instruction at pc
    S_HELD = 1'b1   // one fetched instruction parked in the buffer
  } state_t;

  state_t                  state;
  logic [ADDR_SIZE-1:0]    pc;
  logic [ADDR_SIZE-1:0]    buf_pc;
  logic [INSTR_SIZE-1:0]   buf_instr;

  logic                    redir;
  logic [ADDR_SIZE-1:0]    redir_target;
  logic                    take_resp;
  logic                    deliver_resp;
  logic                    buffer_resp;
  logic                    deliver_buf;

  // A jump is only acted on once decode has actually accepted it; while
  // decode stalls it still holds the jump and will present it again.
  assign redir        = branch_taken | (is_jump & out_valid & ~stall);
  assign redir_target = branch_taken ? branch_addr : jump_addr;

  assign take_resp    = (state == S_REQ) & imem_ready;
  assign deliver_resp = ~redir & take_resp & ~stall;
  assign buffer_resp  = ~redir & take_resp & stall;
  assign deliver_buf  = ~redir & (state == S_HELD) & ~stall;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign state_dbg = (state == S_HELD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_REQ;
      pc              <= RESET_PC;
      out_pc          <= '0;
      out_instruction <= '0;
      out_valid       <= 1'b0;
      buf_pc          <= '0;
      buf_instr       <= '0;
    end else if (redir) begin
      // Squash: drop the output, any buffered instruction and whatever the
      // memory returns this cycle (it belongs to the wrong path).
      pc              <= redir_target;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      state           <= S_REQ;
    end else if (deliver_resp) begin
      out_instruction <= imem_data;
      out_pc          <= pc;
      out_valid       <= 1'b1;
      pc              <= pc + ADDR_SIZE'(4);
    end else if (buffer_resp) begin
      // Decode is stalled but the memory already answered: park it and stop
      // requesting until the buffer drains.
      buf_pc          <= pc;
      buf_instr       <= imem_data;
      pc              <= pc + ADDR_SIZE'(4);
      state           <= S_HELD;
    end else if (deliver_buf) begin
      out_pc          <= buf_pc;
      out_instruction <= buf_instr;
      out_valid       <= 1'b1;
      state           <= S_REQ;
    end else if (!stall) begin
      // Nothing to hand over: insert a NOP bubble.
      out_valid       <= 1'b0;
      out_instruction <= '0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (deliver_resp | deliver_buf)
        perf_fetched <= perf_fetched + 32'd1;
      if ((imem_req & ~imem_ready) | (state == S_HELD))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
